rob_commit: RTL

- In-order retirement stage at the extraction end of the reorder buffer.
- Each cycle it inspects the head EXT_COUNT slots (slot_data/slot_valid) and retires the longest legal contiguous prefix. It drives consume/consume_count back to the ROB.
- Retired results go to register-file write ports, registered with 1-cycle latency.
- At most one retired store per cycle is committed through a valid/ready store-commit port. A halt flag stops retirement permanently until reset.

---
 rtl/rob_commit_pkg.sv | 32 +++
 rtl/rob_commit_select.sv | 66 ++++++
 rtl/rob_commit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rob_commit_pkg.sv
//------------------------------------------------------------------------------
// Module      : pipTypes (package)
// Description : Shared pipeline types. Holds the reorder-buffer entry layout
//               and the retirement-stage state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipTypes;

    // Reorder-buffer entry. Result/destination fields are written by the
    // execute stages; store and halt fields are captured at dispatch.
    typedef struct packed {
        logic        halt;
        logic        is_store;
        logic [3:0]  store_be;
        logic [31:0] store_data;
        logic [31:0] store_addr;
        logic        dest_reg_valid;
        logic [4:0]  dest_reg;
        logic [31:0] result_lo;
    } rob_entry_t;

    // Retirement stage state: RUN retires normally, HALTED is terminal.
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } commit_state_t;

endpackage : pipTypes

`default_nettype wire

// File: rtl/rob_commit_select.sv
//------------------------------------------------------------------------------
// Module      : commit_select
// Description : Combinational retirement selection. Finds the longest legal
//               contiguous prefix of head slots, honouring occupancy, result
//               availability, the one-store-per-cycle limit and halt.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module commit_select #(
    parameter int EXT_COUNT    = 4,
    parameter int DEPTHLOG2    = 4,
    parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
    input  logic                    run,
    input  logic [EXT_COUNT-1:0]    slot_valid,
    input  logic [EXT_COUNT-1:0]    slot_is_store,
    input  logic [EXT_COUNT-1:0]    slot_halt,
    input  logic [DEPTHLOG2:0]      rob_used_count,
    input  logic                    sc_ready,
    output logic [EXT_COUNT-1:0]    retiring,
    output logic [EXTCOUNTLOG2:0]   n,
    output logic                    store_valid,
    output logic [EXTCOUNTLOG2-1:0] store_idx
);

    localparam int c_UW = DEPTHLOG2 + 1;

    logic w_open;
    logic w_take;

    // Walk the slots oldest-first; the first slot that cannot retire closes
    // the prefix, and a retiring halt closes it after itself.
    always_comb begin
        retiring    = '0;
        n           = '0;
        store_valid = 1'b0;
        store_idx   = '0;
        w_open      = run;
        w_take      = 1'b0;
        for (int i = 0; i < EXT_COUNT; i++) begin
            w_take = w_open && (c_UW'(i) < rob_used_count) && slot_valid[i];
            // Only one store may commit per cycle, and only when the store
            // buffer can take it.
            if (w_take && slot_is_store[i] && (store_valid || !sc_ready)) begin
                w_take = 1'b0;
            end
            if (w_take) begin
                retiring[i] = 1'b1;
                n           = n + (EXTCOUNTLOG2 + 1)'(1);
                if (slot_is_store[i]) begin
                    store_valid = 1'b1;
                    store_idx   = EXTCOUNTLOG2'(i);
                end
                if (slot_halt[i]) begin
                    w_open = 1'b0;
                end
            end else begin
                w_open = 1'b0;
            end
        end
    end

endmodule : commit_select

`default_nettype wire

// File: rtl/rob_commit.sv
//------------------------------------------------------------------------------
// Module      : rob_commit
// Description : In-order retirement at the ROB head. Retires up to EXT_COUNT
//               entries per cycle, drives registered regfile writes, commits
//               at most one store per cycle and stops permanently on halt.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rob_commit
    import pipTypes::*;
#(
    parameter type T            = rob_entry_t,
    parameter int  DEPTH        = 16,
    parameter int  EXT_COUNT    = 4,
    parameter int  DEPTHLOG2    = $clog2(DEPTH),
    parameter int  EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  T                        slot_data      [EXT_COUNT],
    input  logic [EXT_COUNT-1:0]    slot_valid,
    input  logic [DEPTHLOG2:0]      rob_used_count,
    output logic                    consume,
    output logic [EXTCOUNTLOG2-1:0] consume_count,
    output logic [EXT_COUNT-1:0]    rf_wr_en,
    output logic [4:0]              rf_wr_addr     [EXT_COUNT],
    output logic [31:0]             rf_wr_data     [EXT_COUNT],
    output logic                    sc_valid,
    input  logic                    sc_ready,
    output logic [31:0]             sc_addr,
    output logic [31:0]             sc_data,
    output logic [3:0]              sc_be,
    output logic                    halted,
    output logic [31:0]             retired_count
);

    commit_state_t r_state;
    logic          r_halted;
    logic [31:0]   r_retired_count;
    logic [EXT_COUNT-1:0] r_wr_en;
    logic [4:0]    r_wr_addr [EXT_COUNT];
    logic [31:0]   r_wr_data [EXT_COUNT];

    logic [EXT_COUNT-1:0]    w_is_store;
    logic [EXT_COUNT-1:0]    w_halt;
    logic [EXT_COUNT-1:0]    w_retiring;
    logic [EXTCOUNTLOG2:0]   w_n;
    logic                    w_store_valid;
    logic [EXTCOUNTLOG2-1:0] w_store_idx;
    logic [EXT_COUNT-1:0]    w_wr_en;
    logic                    w_halt_retire;

    generate
        for (genvar g = 0; g < EXT_COUNT; g++) begin : g_slot_flags
            assign w_is_store[g] = slot_data[g].is_store;
            assign w_halt[g]     = slot_data[g].halt;
        end
    endgenerate

    commit_select #(
        .EXT_COUNT    (EXT_COUNT),
        .DEPTHLOG2    (DEPTHLOG2),
        .EXTCOUNTLOG2 (EXTCOUNTLOG2)
    ) u_select (
        .run            (r_state == RUN),
        .slot_valid     (slot_valid),
        .slot_is_store  (w_is_store),
        .slot_halt      (w_halt),
        .rob_used_count (rob_used_count),
        .sc_ready       (sc_ready),
        .retiring       (w_retiring),
        .n              (w_n),
        .store_valid    (w_store_valid),
        .store_idx      (w_store_idx)
    );

    assign consume       = (w_n != '0);
    assign consume_count = consume ? EXTCOUNTLOG2'(w_n - (EXTCOUNTLOG2 + 1)'(1)) : '0;
    assign sc_valid      = w_store_valid;
    assign sc_addr       = slot_data[w_store_idx].store_addr;
    assign sc_data       = slot_data[w_store_idx].store_data;
    assign sc_be         = slot_data[w_store_idx].store_be;
    assign w_halt_retire = |(w_retiring & w_halt);

    // Write enables: skip r0 and any slot overwritten by a younger retiring
    // slot in the same group, so only the youngest value reaches the regfile.
    always_comb begin
        w_wr_en = '0;
        for (int i = 0; i < EXT_COUNT; i++) begin
            w_wr_en[i] = w_retiring[i] && slot_data[i].dest_reg_valid &&
                         (slot_data[i].dest_reg != 5'd0);
            for (int j = i + 1; j < EXT_COUNT; j++) begin
                if (w_retiring[j] && slot_data[j].dest_reg_valid &&
                    (slot_data[j].dest_reg == slot_data[i].dest_reg)) begin
                    w_wr_en[i] = 1'b0;
                end
            end
        end
    end

    // State, halt flag, retire counter and the registered regfile write port.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state         <= RUN;
            r_halted        <= 1'b0;
            r_retired_count <= '0;
            r_wr_en         <= '0;
            for (int i = 0; i < EXT_COUNT; i++) begin
                r_wr_addr[i] <= '0;
                r_wr_data[i] <= '0;
            end
        end else begin
            if (w_halt_retire) begin
                r_state  <= HALTED;
                r_halted <= 1'b1;
            end
            r_retired_count <= r_retired_count + 32'(w_n);
            r_wr_en         <= w_wr_en;
            for (int i = 0; i < EXT_COUNT; i++) begin
                r_wr_addr[i] <= slot_data[i].dest_reg;
                r_wr_data[i] <= slot_data[i].result_lo;
            end
        end
    end

    assign rf_wr_en      = r_wr_en;
    assign rf_wr_addr    = r_wr_addr;
    assign rf_wr_data    = r_wr_data;
    assign halted        = r_halted;
    assign retired_count = r_retired_count;

endmodule : rob_commit

`default_nettype wire
